operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage of the 16-bit processor, directly upstream of the ALU. It decodes a 16-bit instruction, reads two operands from an 8 x 16-bit register file, and sign-extends an immediate if the instruction uses one. It registers `a`, `b` and `alu_op` for the ALU behind a valid/ready handshake. It also owns the register-file write port, which the writeback path drives, with same-cycle write-to-read bypass.

## Interface
- `DW`, 16: datapath width; only 16 is supported.
- `NREG`, 8: register count; fixed by the 3-bit register fields.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `instr` holds a valid instruction.
- `in_ready`  out  1  stage accepts `instr` this cycle.
- `instr`  in  16  instruction word; format given under Operation.
- `out_valid`  out  1  registered operand bundle is valid.
- `out_ready`  in  1  downstream accepts the bundle this cycle.
- `a`  out  16  ALU operand a, equal to R[rs1].
- `b`  out  16  ALU operand b, equal to R[rs2] or sext(imm6).
- `alu_op`  out  3  ALU opcode, passed through unchanged (0 ADD … 7 SAR).
- `rd`  out  3  destination register, carried to writeback.
- `rd_we`  out  1  the bundle's result is to be written back (rd != 0).
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  3  register-file write address.
- `wb_data`  in  16  register-file write data.

## Operation
- Instruction fields:
  - [15]: I, immediate select.
  - [14:12]: alu_op.
  - [11:9]: rd.
  - [8:6]: rs1.
  - If I=0, [5:3] is rs2 and [2:0] is ignored.
  - If I=1, [5:0] is imm6, sign-extended to 16 bits by replicating bit 5.
- Register file: R0 reads 0 permanently, and writes to R0 are dropped. R1..R7 are writable.
- Write: when `wb_en`=1 and `wb_addr`!=0, R[`wb_addr`] takes `wb_data` on the clock edge.
- Reads are combinational.
- Bypass: when `wb_en`=1, `wb_addr`!=0 and `wb_addr` equals rs1 (or rs2 when I=0), the read returns `wb_data` instead of the stored value.
- Output register behaviour:
  - Load: a load occurs when `in_valid` && `in_ready`. It captures a, b, alu_op, rd and rd_we=(rd!=0), and sets `out_valid`=1.
  - Held bundle: the bundle stays stable until accepted (`out_valid` && `out_ready`).
  - Frozen operands: held operands are not refreshed by later writebacks. RAW hazards across a stall are the responsibility of the hazard/issue logic.
  - Idle: on accept with no simultaneous load, `out_valid` goes to 0.
  - Accept and load together: the new bundle replaces the old one with no bubble.
- `in_ready` = !rst && (!`out_valid` || `out_ready`). It is combinational, with no path from `in_valid`.
- State (two states, implied by `out_valid`):
  - EMPTY to FULL on load.
  - FULL to FULL on accept+load, or when stalled.
  - FULL to EMPTY on accept without load.

## Timing
- Reset, while `rst`=1 at an edge:
  - R1..R7 are set to 0.
  - `out_valid`, `a`, `b`, `alu_op`, `rd` and `rd_we` are set to 0.
  - `in_ready` is 0.
  - `wb_en` and `in_valid` are ignored.
- Reset mid-operation: a held bundle is discarded. `out_valid` is 0 in the cycle after the reset edge.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, with `out_valid`=1. Throughput is one instruction per cycle while `out_ready`=1.
- Write then read:
  - A write at edge N is visible to reads in cycle N+1 from the array.
  - A read in the same cycle as the write sees the new data through the bypass.
- Outputs are registered. `a`, `b` and `alu_op` drive the combinational ALU directly.

## Test plan
- Reset and bypass:
  - Stimulus: assert `rst` with `wb_en`=1, `wb_addr`=3, `wb_data`=0x1234.
  - Required: after release, `out_valid`=0, `in_ready`=1, `a`=`b`=0, and R3 reads 0.
- Write then read:
  - Stimulus: write R1=54 and R2=5. Then issue I=0, alu_op=1, rd=4, rs1=1, rs2=2.
  - Required: next cycle `a`=54, `b`=5, `alu_op`=1, `rd`=4, `rd_we`=1, `out_valid`=1.
- Immediate and R0:
  - Stimulus: issue I=1, rs1=0, imm6=0x3B.
  - Required: `a`=0, `b`=0xFFFB.
  - Stimulus: with imm6=0x05.
  - Required: `b`=0x0005.
  - Stimulus: `wb_en`=1, `wb_addr`=0, `wb_data`=7.
  - Required: R0 still reads 0.
- Same-cycle bypass:
  - Stimulus: `wb_en`=1, `wb_addr`=5, `wb_data`=0xBEEF in the same cycle as an instruction with rs1=5 and rs2=5.
  - Required: `a`=`b`=0xBEEF.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: the bundle is unchanged, `in_ready`=0, and a write to its source register does not alter `a`.
  - Stimulus: raise `out_ready`.
  - Required: the next instruction loads in the same cycle and `out_valid` stays 1.
- Mid-stall reset:
  - Stimulus: pulse `rst` while `out_valid`=1 and `out_ready`=0.
  - Required: `out_valid`=0 and all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//
// Operand-fetch stage of the 16-bit processor, sitting directly in front of
// the ALU. Each cycle it can:
//   * decode one 16-bit instruction,
//   * read two operands from an 8 x 16-bit register file,
//   * sign-extend a 6-bit immediate when the instruction uses one,
//   * register a, b, alu_op, rd and rd_we behind a valid/ready handshake.
// The stage also owns the register-file write port. The writeback path drives
// that port, and a same-cycle write-to-read bypass is provided.
//
// Instruction format:
//   [15]    I       immediate select
//   [14:12] alu_op
//   [11:9]  rd
//   [8:6]   rs1
//   [5:3]   rs2     (I = 0, bits [2:0] ignored)
//   [5:0]   imm6    (I = 1, sign-extended from bit 5)
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   instr holds a valid instruction
//   in_ready   out  1   stage accepts instr this cycle
//   instr      in   16  instruction word
//   out_valid  out  1   registered operand bundle is valid
//   out_ready  in   1   downstream accepts the bundle this cycle
//   a          out  16  operand a = R[rs1]
//   b          out  16  operand b = R[rs2] or sext(imm6)
//   alu_op     out  3   ALU opcode, passed through
//   rd         out  3   destination register
//   rd_we      out  1   result is written back (rd != 0)
//   wb_en      in   1   register-file write enable
//   wb_addr    in   3   register-file write address
//   wb_data    in   16  register-file write data
// -----------------------------------------------------------------------------
module operand_fetch #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [2:0]    alu_op,
  output logic [2:0]    rd,
  output logic          rd_we,
  input  logic          wb_en,
  input  logic [2:0]    wb_addr,
  input  logic [DW-1:0] wb_data
);

  // Two-state view of the output register. The state is held explicitly so
  // that out_valid is a plain decode of a registered state.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t state_r;

  // R1..R(NREG-1). R0 has no storage because it always reads as zero.
  logic [NREG-1:1][DW-1:0] regs_r;

  // Decoded instruction fields
  logic          imm_sel_s;
  logic [2:0]    op_s;
  logic [2:0]    rd_s;
  logic [2:0]    rs1_s;
  logic [2:0]    rs2_s;
  logic [DW-1:0] imm_ext_s;

  // Operand values and handshake
  logic [DW-1:0] a_next_s;
  logic [DW-1:0] b_next_s;
  logic          wr_s;
  logic          load_s;
  logic          accept_s;

  // Output registers
  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic [2:0]    alu_op_r;
  logic [2:0]    rd_r;
  logic          rd_we_r;

  // Sign-extend a 6-bit immediate to the datapath width.
  function automatic logic [DW-1:0] sext6(input logic [5:0] imm);
    sext6 = {{(DW-6){imm[5]}}, imm};
  endfunction

  // Read port with bypass. Address 0 is hard-wired to zero, even when the
  // write port targets it, because writes to R0 are dropped. A live write to
  // the same address wins over the stored value.
  function automatic logic [DW-1:0] read_port(
    input logic [2:0]              addr,
    input logic [NREG-1:1][DW-1:0] file,
    input logic                    we,
    input logic [2:0]              waddr,
    input logic [DW-1:0]           wdata
  );
    logic [DW-1:0] v;
    if (addr == 3'd0) begin
      v = {DW{1'b0}};
    end else if (we && (waddr == addr)) begin
      v = wdata;
    end else begin
      case (addr)
        3'd1:    v = file[1];
        3'd2:    v = file[2];
        3'd3:    v = file[3];
        3'd4:    v = file[4];
        3'd5:    v = file[5];
        3'd6:    v = file[6];
        3'd7:    v = file[7];
        default: v = {DW{1'b0}};
      endcase
    end
    return v;
  endfunction

  // Instruction field decode
  always_comb begin
    imm_sel_s = instr[15];
    op_s      = instr[14:12];
    rd_s      = instr[11:9];
    rs1_s     = instr[8:6];
    rs2_s     = instr[5:3];
    imm_ext_s = sext6(instr[5:0]);
  end

  // Effective write strobe. Writes to R0 are discarded here so that neither
  // the array nor the bypass ever sees them.
  always_comb begin
    wr_s = wb_en && (wb_addr != 3'd0);
  end

  // Operand selection. When I=1 the rs2 field is part of the immediate, so
  // the rs2 read and its bypass are not used.
  always_comb begin
    a_next_s = read_port(rs1_s, regs_r, wr_s, wb_addr, wb_data);
    if (imm_sel_s) begin
      b_next_s = imm_ext_s;
    end else begin
      b_next_s = read_port(rs2_s, regs_r, wr_s, wb_addr, wb_data);
    end
  end

  // Handshake. in_ready is a function of reset, state and out_ready only, so
  // there is no combinational path from in_valid.
  always_comb begin
    in_ready = !rst && ((state_r == ST_EMPTY) || out_ready);
    load_s   = in_valid && in_ready;
    accept_s = (state_r == ST_FULL) && out_ready;
  end

  // Register-file write port. Reset clears R1..R7 and ignores wb_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r <= '0;
    end else if (wr_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Output-bundle FSM. A load takes priority over the accept, so that accept
  // and load together replace the bundle with no bubble. While stalled, the
  // operands stay frozen even if a writeback hits their source registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_EMPTY;
      a_r      <= {DW{1'b0}};
      b_r      <= {DW{1'b0}};
      alu_op_r <= 3'd0;
      rd_r     <= 3'd0;
      rd_we_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (load_s) begin
            state_r  <= ST_FULL;
            a_r      <= a_next_s;
            b_r      <= b_next_s;
            alu_op_r <= op_s;
            rd_r     <= rd_s;
            rd_we_r  <= (rd_s != 3'd0);
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (load_s) begin
            state_r  <= ST_FULL;
            a_r      <= a_next_s;
            b_r      <= b_next_s;
            alu_op_r <= op_s;
            rd_r     <= rd_s;
            rd_we_r  <= (rd_s != 3'd0);
          end else if (accept_s) begin
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_FULL;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
        end
      endcase
    end
  end

  // Registered outputs
  always_comb begin
    out_valid = (state_r == ST_FULL);
    a         = a_r;
    b         = b_r;
    alu_op    = alu_op_r;
    rd        = rd_r;
    rd_we     = rd_we_r;
  end

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//
// Directed testbench for operand_fetch. The stimulus is a linear sequence of
// steps, and the expected values are computed by hand. Inputs are driven 1
// time unit after the rising edge, and outputs are sampled 1 time unit after
// the rising edge, which keeps both away from the active clock edge.
// -----------------------------------------------------------------------------
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  alu_op;
  logic [2:0]  rd;
  logic        rd_we;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;

  int checks   = 0;
  int failures = 0;

  operand_fetch #(.DW(16), .NREG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .rd        (rd),
    .rd_we     (rd_we),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-register instruction encoding
  function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [2:0] s2);
    return {1'b0, op, d, s1, s2, 3'b000};
  endfunction

  // Immediate instruction encoding
  function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] d,
                                        input logic [2:0] s1, input logic [5:0] imm);
    return {1'b1, op, d, s1, imm};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and move to the sampling/driving point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = 16'h0000;
    out_ready = 1'b1;
    wb_en     = 1'b1;
    wb_addr   = 3'd3;
    wb_data   = 16'h1234;
    #1;
    chk("in_ready_in_reset", {15'd0, in_ready}, 16'd0);

    // Reset with a write pending to R3. The write must be ignored.
    tick();
    tick();
    rst   = 1'b0;
    wb_en = 1'b0;
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_in_ready",  {15'd0, in_ready},  16'd1);
    chk("rst_a", a, 16'h0000);
    chk("rst_b", b, 16'h0000);

    // Issue an instruction that reads R3 and writes R0.
    in_valid = 1'b1;
    instr    = enc_r(3'd0, 3'd0, 3'd3, 3'd3);
    tick();
    chk("r3_after_rst_a",  a, 16'h0000);
    chk("r3_after_rst_b",  b, 16'h0000);
    chk("rd0_rd_we",       {15'd0, rd_we},     16'd0);
    chk("r3_out_valid",    {15'd0, out_valid}, 16'd1);

    // Write R1=54 with no new instruction. The bundle is accepted and the
    // stage goes idle.
    in_valid = 1'b0;
    wb_en    = 1'b1;
    wb_addr  = 3'd1;
    wb_data  = 16'd54;
    tick();
    chk("idle_out_valid", {15'd0, out_valid}, 16'd0);
    wb_addr = 3'd2;
    wb_data = 16'd5;
    tick();
    wb_en    = 1'b0;
    in_valid = 1'b1;
    instr    = enc_r(3'd1, 3'd4, 3'd1, 3'd2);
    tick();
    chk("wr_rd_a",      a, 16'd54);
    chk("wr_rd_b",      b, 16'd5);
    chk("wr_rd_alu_op", {13'd0, alu_op}, 16'd1);
    chk("wr_rd_rd",     {13'd0, rd},     16'd4);
    chk("wr_rd_rd_we",  {15'd0, rd_we},  16'd1);
    chk("wr_rd_valid",  {15'd0, out_valid}, 16'd1);

    // Immediate with a negative imm6, and rs1 = R0
    instr = enc_i(3'd0, 3'd3, 3'd0, 6'h3B);
    tick();
    chk("imm_neg_a", a, 16'h0000);
    chk("imm_neg_b", b, 16'hFFFB);
    instr = enc_i(3'd2, 3'd3, 3'd1, 6'h05);
    tick();
    chk("imm_pos_a", a, 16'd54);
    chk("imm_pos_b", b, 16'h0005);

    // A write to R0 is dropped, both through the bypass and in the array.
    wb_en   = 1'b1;
    wb_addr = 3'd0;
    wb_data = 16'd7;
    instr   = enc_r(3'd0, 3'd1, 3'd0, 3'd0);
    tick();
    chk("r0_bypass_a", a, 16'h0000);
    chk("r0_bypass_b", b, 16'h0000);
    wb_en = 1'b0;
    tick();
    chk("r0_array_a", a, 16'h0000);

    // Same-cycle bypass on both ports
    wb_en   = 1'b1;
    wb_addr = 3'd5;
    wb_data = 16'hBEEF;
    instr   = enc_r(3'd2, 3'd6, 3'd5, 3'd5);
    tick();
    chk("bypass_a", a, 16'hBEEF);
    chk("bypass_b", b, 16'hBEEF);
    wb_en = 1'b0;
    instr = enc_r(3'd0, 3'd1, 3'd5, 3'd1);
    tick();
    chk("array_r5_a", a, 16'hBEEF);
    chk("array_r1_b", b, 16'd54);

    // Backpressure. Load X while out_ready=1, then stall with Y waiting.
    instr = enc_r(3'd3, 3'd7, 3'd1, 3'd2);
    tick();
    chk("x_a", a, 16'd54);
    out_ready = 1'b0;
    instr     = enc_r(3'd4, 3'd2, 3'd2, 3'd1);
    wb_en     = 1'b1;
    wb_addr   = 3'd1;
    wb_data   = 16'h1111;
    #1;
    chk("stall_in_ready", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      wb_en = 1'b0;
      chk("stall_a",      a, 16'd54);
      chk("stall_b",      b, 16'd5);
      chk("stall_alu_op", {13'd0, alu_op}, 16'd3);
      chk("stall_rd",     {13'd0, rd},     16'd7);
      chk("stall_valid",  {15'd0, out_valid}, 16'd1);
      chk("stall_ready",  {15'd0, in_ready},  16'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {15'd0, in_ready}, 16'd1);
    tick();
    chk("y_a",      a, 16'd5);
    chk("y_b",      b, 16'h1111);
    chk("y_alu_op", {13'd0, alu_op}, 16'd4);
    chk("y_rd",     {13'd0, rd},     16'd2);
    chk("y_valid",  {15'd0, out_valid}, 16'd1);

    // Reset while the stage is stalled with a bundle held
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("pre_rst_valid", {15'd0, out_valid}, 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid",  {15'd0, out_valid}, 16'd0);
    chk("mid_rst_a",      a, 16'h0000);
    chk("mid_rst_b",      b, 16'h0000);
    chk("mid_rst_alu_op", {13'd0, alu_op}, 16'd0);
    chk("mid_rst_rd",     {13'd0, rd},     16'd0);
    chk("mid_rst_rd_we",  {15'd0, rd_we},  16'd0);

    // The register file is cleared by reset as well.
    in_valid = 1'b1;
    instr    = enc_r(3'd0, 3'd1, 3'd1, 3'd5);
    tick();
    chk("r1_cleared", a, 16'h0000);
    chk("r5_cleared", b, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
